// File: rtl/reorder_buffer_8wide_if.sv
// Signal bundle between rename, writeback, retire and the 8-wide reorder buffer.
// Handshake: alloc lane k is consumed only in a cycle where can_allocate_rob8_o
// is 1; otherwise rename must keep presenting the same lanes. Writeback strobes
// and commit slots are single-cycle pulses with no backpressure.
interface reorder_buffer_8wide_if #(
   parameter int ROB_DEPTH = 64,
   parameter int PHYS_W    = 7,
   parameter int WB_PORTS  = 4
);
   localparam int IDX_W = $clog2(ROB_DEPTH);

   logic [7:0]                          alloc_valid_i;
   logic [7:0]                          alloc_has_rd_i;
   logic [7:0][4:0]                     alloc_rd_arch_i;
   logic [7:0][PHYS_W-1:0]              alloc_rd_phys_i;
   logic [7:0][PHYS_W-1:0]              alloc_old_phys_i;
   logic                                can_allocate_rob8_o;
   logic [7:0][IDX_W-1:0]               alloc_idx_o;
   logic [WB_PORTS-1:0]                 wb_valid_i;
   logic [WB_PORTS-1:0][IDX_W-1:0]      wb_idx_i;
   logic                                flush_i;
   logic [7:0]                          commit_valid_o;
   logic [7:0]                          commit_has_rd_o;
   logic [7:0][4:0]                     commit_rd_arch_o;
   logic [7:0][PHYS_W-1:0]              commit_rd_phys_o;
   logic [7:0][PHYS_W-1:0]              commit_free_phys_o;
   logic [IDX_W:0]                      rob_count_o;

   modport master (
      output alloc_valid_i, alloc_has_rd_i, alloc_rd_arch_i, alloc_rd_phys_i,
             alloc_old_phys_i, wb_valid_i, wb_idx_i, flush_i,
      input  can_allocate_rob8_o, alloc_idx_o, commit_valid_o, commit_has_rd_o,
             commit_rd_arch_o, commit_rd_phys_o, commit_free_phys_o, rob_count_o
   );

   modport slave (
      input  alloc_valid_i, alloc_has_rd_i, alloc_rd_arch_i, alloc_rd_phys_i,
             alloc_old_phys_i, wb_valid_i, wb_idx_i, flush_i,
      output can_allocate_rob8_o, alloc_idx_o, commit_valid_o, commit_has_rd_o,
             commit_rd_arch_o, commit_rd_phys_o, commit_free_phys_o, rob_count_o
   );
endinterface

// File: rtl/reorder_buffer_8wide.sv
// Circular reorder buffer behind the 8-wide rename stage: allocates up to 8
// entries per cycle, marks them done on writeback and retires up to 8 per cycle
// in program order, returning each retired old mapping to the free list.
module reorder_buffer_8wide #(
   parameter int ROB_DEPTH = 64,
   parameter int PHYS_W    = 7,
   parameter int WB_PORTS  = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   reorder_buffer_8wide_if.slave  rob
);
   localparam int IDX_W = $clog2(ROB_DEPTH);
   localparam logic [IDX_W:0] ALLOC_LIMIT = (IDX_W+1)'(ROB_DEPTH - 8);

   logic [IDX_W-1:0]       head_q;
   logic [IDX_W-1:0]       tail_q;
   logic [IDX_W:0]         count_q;
   logic [IDX_W:0]         count_d;
   logic [ROB_DEPTH-1:0]   valid_q;
   logic [ROB_DEPTH-1:0]   valid_d;
   logic [ROB_DEPTH-1:0]   done_q;
   logic [ROB_DEPTH-1:0]   done_d;

   logic [ROB_DEPTH-1:0]   has_rd_mem;
   logic [4:0]             rd_arch_mem  [ROB_DEPTH];
   logic [PHYS_W-1:0]      rd_phys_mem  [ROB_DEPTH];
   logic [PHYS_W-1:0]      old_phys_mem [ROB_DEPTH];

   logic                   can_alloc;
   logic [3:0]             n_alloc_lanes;
   logic [3:0]             n_alloc;
   logic [3:0]             n_commit;
   logic                   commit_run;
   logic [7:0]             commit_mask;
   logic [7:0][IDX_W-1:0]  alloc_idx;
   logic [7:0][IDX_W-1:0]  slot_idx;

   // Free-space decision comes from the registered count only, so rename sees
   // a stable flag for the whole cycle.
   assign can_alloc = (count_q <= ALLOC_LIMIT);
   assign n_alloc   = can_alloc ? n_alloc_lanes : 4'd0;
   assign count_d   = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_commit);

   assign rob.can_allocate_rob8_o = can_alloc;
   assign rob.alloc_idx_o         = alloc_idx;
   assign rob.rob_count_o         = count_q;

   // Compact valid lanes onto consecutive slots starting at tail.
   always_comb begin
      n_alloc_lanes = '0;
      for (int k = 0; k < 8; k++) begin
         alloc_idx[k]  = tail_q + IDX_W'(n_alloc_lanes);
         n_alloc_lanes = n_alloc_lanes + 4'(rob.alloc_valid_i[k]);
      end
   end

   // Length of the valid-and-done run starting at head, at most 8 slots.
   always_comb begin
      n_commit    = '0;
      commit_mask = '0;
      commit_run  = 1'b1;
      for (int j = 0; j < 8; j++) begin
         slot_idx[j] = head_q + IDX_W'(j);
         if (commit_run && valid_q[slot_idx[j]] && done_q[slot_idx[j]]) begin
            commit_mask[j] = 1'b1;
            n_commit       = n_commit + 4'd1;
         end else begin
            commit_run = 1'b0;
         end
      end
   end

   // Next valid/done bits: writeback marks, retirement clears, allocation reopens.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (rob.wb_valid_i[p] && valid_q[rob.wb_idx_i[p]]) begin
            done_d[rob.wb_idx_i[p]] = 1'b1;
         end
      end
      for (int j = 0; j < 8; j++) begin
         if (commit_mask[j]) begin
            valid_d[slot_idx[j]] = 1'b0;
            done_d[slot_idx[j]]  = 1'b0;
         end
      end
      if (can_alloc) begin
         for (int k = 0; k < 8; k++) begin
            if (rob.alloc_valid_i[k]) begin
               valid_d[alloc_idx[k]] = 1'b1;
               done_d[alloc_idx[k]]  = 1'b0;
            end
         end
      end
   end

   // Pointer, status and registered commit slots; flush wins over everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q                 <= '0;
         tail_q                 <= '0;
         count_q                <= '0;
         valid_q                <= '0;
         done_q                 <= '0;
         rob.commit_valid_o     <= '0;
         rob.commit_has_rd_o    <= '0;
         rob.commit_rd_arch_o   <= '0;
         rob.commit_rd_phys_o   <= '0;
         rob.commit_free_phys_o <= '0;
      end else if (rob.flush_i) begin
         head_q                 <= '0;
         tail_q                 <= '0;
         count_q                <= '0;
         valid_q                <= '0;
         done_q                 <= '0;
         rob.commit_valid_o     <= '0;
         rob.commit_has_rd_o    <= '0;
         rob.commit_rd_arch_o   <= '0;
         rob.commit_rd_phys_o   <= '0;
         rob.commit_free_phys_o <= '0;
      end else begin
         head_q             <= head_q + IDX_W'(n_commit);
         tail_q             <= tail_q + IDX_W'(n_alloc);
         count_q            <= count_d;
         valid_q            <= valid_d;
         done_q             <= done_d;
         rob.commit_valid_o <= commit_mask;
         for (int j = 0; j < 8; j++) begin
            rob.commit_has_rd_o[j]    <= commit_mask[j] & has_rd_mem[slot_idx[j]];
            rob.commit_rd_arch_o[j]   <= commit_mask[j] ? rd_arch_mem[slot_idx[j]]  : '0;
            rob.commit_rd_phys_o[j]   <= commit_mask[j] ? rd_phys_mem[slot_idx[j]]  : '0;
            rob.commit_free_phys_o[j] <= commit_mask[j] ? old_phys_mem[slot_idx[j]] : '0;
         end
      end
   end

   // Payload storage; written only for lanes that are actually accepted.
   always_ff @(posedge clk) begin
      if (can_alloc && !rob.flush_i) begin
         for (int k = 0; k < 8; k++) begin
            if (rob.alloc_valid_i[k]) begin
               has_rd_mem[alloc_idx[k]]   <= rob.alloc_has_rd_i[k];
               rd_arch_mem[alloc_idx[k]]  <= rob.alloc_rd_arch_i[k];
               rd_phys_mem[alloc_idx[k]]  <= rob.alloc_rd_phys_i[k];
               old_phys_mem[alloc_idx[k]] <= rob.alloc_old_phys_i[k];
            end
         end
      end
   end
endmodule
